// File: rtl/demux1_16_8b_reg.sv
// demux1_16_8b_reg: distributes a byte into one of 16 registered lanes.
// Lanes are addressed either directly by {S3,S2,S1,S0} or by an internal
// pointer. Each lane has a valid flag that the consumer clears via Leido.
// A write to an occupied, unacknowledged lane is dropped and flagged.
module demux1_16_8b_reg (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   Entrada,
  input  logic         S3,
  input  logic         S2,
  input  logic         S1,
  input  logic         S0,
  input  logic         Modo,
  input  logic         Escribir,
  input  logic [15:0]  Leido,
  output logic [127:0] Salida,
  output logic [15:0]  Valido,
  output logic [3:0]   Puntero,
  output logic [4:0]   Cuenta,
  output logic         Lleno,
  output logic         Rechazo
);

  logic [15:0][7:0] r_lane;
  logic [15:0]      r_valid;
  logic [3:0]       r_ptr;
  logic [4:0]       r_cnt;
  logic             r_rechazo;

  logic [3:0]       w_target;
  logic             w_accept;
  logic             w_drop;
  logic [15:0]      w_valid_nxt;
  logic [4:0]       w_cnt_nxt;

  // Target lane selection and accept/drop decision for the current strobe
  always_comb begin
    w_target = Modo ? r_ptr : {S3, S2, S1, S0};
    w_accept = Escribir & (~r_valid[w_target] | Leido[w_target]);
    w_drop   = Escribir & r_valid[w_target] & ~Leido[w_target];
  end

  // Next valid vector: acknowledges clear, an accepted write sets (and wins)
  always_comb begin
    w_valid_nxt = r_valid & ~Leido;
    if (w_accept) begin
      w_valid_nxt[w_target] = 1'b1;
    end
  end

  // Population count of the next valid vector, so Cuenta tracks Valido exactly
  always_comb begin
    w_cnt_nxt = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      w_cnt_nxt = w_cnt_nxt + {4'b0000, w_valid_nxt[i]};
    end
  end

  // Lane data registers: only the accepted target lane loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane <= '0;
    end else if (w_accept) begin
      r_lane[w_target] <= Entrada;
    end
  end

  // Valid flags, occupancy count and drop pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= '0;
      r_cnt     <= '0;
      r_rechazo <= 1'b0;
    end else begin
      r_valid   <= w_valid_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rechazo <= w_drop;
    end
  end

  // Sequential-mode pointer advances only on an accepted write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (Modo && w_accept) begin
      r_ptr <= r_ptr + 4'd1;
    end
  end

  assign Salida  = r_lane;
  assign Valido  = r_valid;
  assign Puntero = r_ptr;
  assign Cuenta  = r_cnt;
  assign Rechazo = r_rechazo;
  assign Lleno   = &r_valid;

endmodule

// File: tb/tb_demux1_16_8b_reg.sv
// Directed bench for demux1_16_8b_reg with hand-computed expectations.
module tb_demux1_16_8b_reg;

  logic         clk;
  logic         rst_n;
  logic [7:0]   Entrada;
  logic         S3, S2, S1, S0;
  logic         Modo;
  logic         Escribir;
  logic [15:0]  Leido;
  logic [127:0] Salida;
  logic [15:0]  Valido;
  logic [3:0]   Puntero;
  logic [4:0]   Cuenta;
  logic         Lleno;
  logic         Rechazo;

  int unsigned n_pass;
  int unsigned n_total;

  demux1_16_8b_reg dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Entrada  (Entrada),
    .S3       (S3),
    .S2       (S2),
    .S1       (S1),
    .S0       (S0),
    .Modo     (Modo),
    .Escribir (Escribir),
    .Leido    (Leido),
    .Salida   (Salida),
    .Valido   (Valido),
    .Puntero  (Puntero),
    .Cuenta   (Cuenta),
    .Lleno    (Lleno),
    .Rechazo  (Rechazo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [3:0] a);
    {S3, S2, S1, S0} = a;
  endtask

  function automatic logic [7:0] lane(input logic [127:0] v, input int unsigned i);
    return v[i*8 +: 8];
  endfunction

  logic [127:0] exp_sal;

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b1;
    Entrada = '0; Modo = 1'b0; Escribir = 1'b0; Leido = '0;
    set_addr(4'd0);

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_salida", Salida, '0);
    check("rst_valido", 128'(Valido), '0);
    check("rst_puntero", 128'(Puntero), '0);
    check("rst_cuenta", 128'(Cuenta), '0);
    check("rst_rechazo", 128'(Rechazo), '0);
    check("rst_lleno", 128'(Lleno), '0);
    tick();
    rst_n = 1'b1;

    // Addressed write to lane 7
    Modo = 1'b0; set_addr(4'b0111); Entrada = 8'hF0; Escribir = 1'b1;
    tick();
    Escribir = 1'b0;
    check("a_lane7", 128'(lane(Salida, 7)), 128'h0F0);
    check("a_valido", 128'(Valido), 128'h0080);
    check("a_cuenta", 128'(Cuenta), 128'd1);
    check("a_rechazo", 128'(Rechazo), 128'd0);

    // Collision without acknowledge: dropped
    Entrada = 8'h11; Escribir = 1'b1; Leido = '0;
    tick();
    Escribir = 1'b0;
    check("c_lane7_hold", 128'(lane(Salida, 7)), 128'h0F0);
    check("c_rechazo", 128'(Rechazo), 128'd1);
    check("c_valido", 128'(Valido), 128'h0080);
    tick();
    check("c_rechazo_end", 128'(Rechazo), 128'd0);

    // Collision with acknowledge on same lane: write wins
    Escribir = 1'b1; Leido = 16'h0080;
    tick();
    Escribir = 1'b0; Leido = '0;
    check("c2_lane7", 128'(lane(Salida, 7)), 128'h011);
    check("c2_valido", 128'(Valido), 128'h0080);
    check("c2_rechazo", 128'(Rechazo), 128'd0);
    check("c2_cuenta", 128'(Cuenta), 128'd1);

    // Acknowledge on an empty lane has no effect
    Leido = 16'h0001;
    tick();
    Leido = '0;
    check("nop_valido", 128'(Valido), 128'h0080);
    check("nop_cuenta", 128'(Cuenta), 128'd1);

    // Clear lane 7; data holds
    Leido = 16'h0080;
    tick();
    Leido = '0;
    check("clr_valido", 128'(Valido), 128'h0000);
    check("clr_cuenta", 128'(Cuenta), 128'd0);
    check("clr_lane7", 128'(lane(Salida, 7)), 128'h011);
    check("addr_ptr", 128'(Puntero), 128'd0);

    // Sequential fill of all 16 lanes
    Modo = 1'b1;
    exp_sal = '0;
    for (int i = 0; i < 16; i++) begin
      Entrada = 8'(i); Escribir = 1'b1;
      exp_sal[i*8 +: 8] = 8'(i);
      tick();
      check("seq_ptr", 128'(Puntero), 128'((i + 1) % 16));
    end
    Escribir = 1'b0;
    check("seq_salida", Salida, exp_sal);
    check("seq_lleno", 128'(Lleno), 128'd1);
    check("seq_cuenta", 128'(Cuenta), 128'd16);
    check("seq_valido", 128'(Valido), 128'hFFFF);

    // 17th write is dropped, pointer holds
    Entrada = 8'hAA; Escribir = 1'b1;
    tick();
    Escribir = 1'b0;
    check("seq17_rechazo", 128'(Rechazo), 128'd1);
    check("seq17_ptr", 128'(Puntero), 128'd0);
    check("seq17_salida", Salida, exp_sal);
    tick();
    check("seq17_rech_end", 128'(Rechazo), 128'd0);

    // Mode change leaves pointer alone
    Modo = 1'b0;
    tick();
    check("modo_ptr", 128'(Puntero), 128'd0);

    // Bulk acknowledge of lower 8 lanes
    Leido = 16'h00FF;
    tick();
    Leido = '0;
    check("bulk_valido", 128'(Valido), 128'hFF00);
    check("bulk_cuenta", 128'(Cuenta), 128'd8);
    check("bulk_lleno", 128'(Lleno), 128'd0);
    check("bulk_salida", Salida, exp_sal);

    // Make lane 5 valid again
    set_addr(4'd5); Entrada = 8'h55; Escribir = 1'b1;
    tick();
    Escribir = 1'b0;
    exp_sal[5*8 +: 8] = 8'h55;
    check("l5_valido", 128'(Valido), 128'hFF20);
    check("l5_cuenta", 128'(Cuenta), 128'd9);

    // Simultaneous write to lane 3 and acknowledge of lane 5
    set_addr(4'd3); Entrada = 8'h33; Escribir = 1'b1; Leido = 16'h0020;
    tick();
    Escribir = 1'b0; Leido = '0;
    exp_sal[3*8 +: 8] = 8'h33;
    check("sim_valido", 128'(Valido), 128'hFF08);
    check("sim_cuenta", 128'(Cuenta), 128'd9);
    check("sim_salida", Salida, exp_sal);

    // Drop to create a pending Rechazo, then async reset mid-cycle
    set_addr(4'd3); Entrada = 8'h99; Escribir = 1'b1;
    tick();
    Escribir = 1'b0;
    check("pre_rst_rechazo", 128'(Rechazo), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_salida", Salida, '0);
    check("arst_valido", 128'(Valido), '0);
    check("arst_cuenta", 128'(Cuenta), '0);
    check("arst_rechazo", 128'(Rechazo), '0);
    check("arst_lleno", 128'(Lleno), '0);
    check("arst_ptr", 128'(Puntero), '0);

    // First edge after release processes inputs normally
    #1 rst_n = 1'b1;
    set_addr(4'd2); Entrada = 8'h5A; Escribir = 1'b1;
    tick();
    Escribir = 1'b0;
    check("post_valido", 128'(Valido), 128'h0004);
    check("post_lane2", 128'(lane(Salida, 2)), 128'h05A);
    check("post_cuenta", 128'(Cuenta), 128'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
